// File: rtl/axi_ddr_pkg.sv
// Shared types and constants for the DDR-port transaction limiter.
// Holds the drain FSM state encoding, AXI response/burst codes and a counter-width helper.
package axi_ddr_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axi_ddr_txn_counter.sv
// Up/down occupancy counter, saturating at MAX and floored at zero.
// A decrement at zero (without a paired increment) holds the count and pulses underflow_o.
module axi_ddr_txn_counter
  import axi_ddr_pkg::*;
#(
  parameter  int unsigned MAX = 8,
  localparam int unsigned CW  = cnt_width(MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          underflow_o
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  always_comb begin
    count_d     = count_q;
    underflow_o = 1'b0;
    case ({inc_i, dec_i})
      2'b10: if (count_q != MAX_C) count_d = count_q + CW'(1);
      2'b01: begin
        if (count_q == '0) underflow_o = 1'b1;
        else               count_d     = count_q - CW'(1);
      end
      default: ;
    endcase
  end

  assign count_o = count_q;

endmodule

// File: rtl/axi_ddr_txn_limiter.sv
// AXI4 pass-through to the DDR controller: caps outstanding writes/reads, holds W
// until its AW is accepted downstream, and offers a drain handshake for quiescing.
module axi_ddr_txn_limiter
  import axi_ddr_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH   = 32,
  parameter  int unsigned DATA_WIDTH   = 32,
  parameter  int unsigned ID_WIDTH     = 4,
  parameter  int unsigned USER_WIDTH   = 1,
  parameter  int unsigned MAX_WR_OUTST = 8,
  parameter  int unsigned MAX_RD_OUTST = 8,
  localparam int unsigned WR_CW        = cnt_width(MAX_WR_OUTST),
  localparam int unsigned RD_CW        = cnt_width(MAX_RD_OUTST)
) (
  input  logic                    clk,
  input  logic                    rst,
  // AW
  input  logic [ADDR_WIDTH-1:0]   s_aw_addr,
  input  logic [2:0]              s_aw_prot,
  input  logic [3:0]              s_aw_region,
  input  logic [7:0]              s_aw_len,
  input  logic [2:0]              s_aw_size,
  input  logic [1:0]              s_aw_burst,
  input  logic                    s_aw_lock,
  input  logic [3:0]              s_aw_cache,
  input  logic [3:0]              s_aw_qos,
  input  logic [ID_WIDTH-1:0]     s_aw_id,
  input  logic [USER_WIDTH-1:0]   s_aw_user,
  input  logic                    s_aw_valid,
  output logic                    s_aw_ready,
  output logic [ADDR_WIDTH-1:0]   m_aw_addr,
  output logic [2:0]              m_aw_prot,
  output logic [3:0]              m_aw_region,
  output logic [7:0]              m_aw_len,
  output logic [2:0]              m_aw_size,
  output logic [1:0]              m_aw_burst,
  output logic                    m_aw_lock,
  output logic [3:0]              m_aw_cache,
  output logic [3:0]              m_aw_qos,
  output logic [ID_WIDTH-1:0]     m_aw_id,
  output logic [USER_WIDTH-1:0]   m_aw_user,
  output logic                    m_aw_valid,
  input  logic                    m_aw_ready,
  // W
  input  logic [DATA_WIDTH-1:0]   s_w_data,
  input  logic [DATA_WIDTH/8-1:0] s_w_strb,
  input  logic [USER_WIDTH-1:0]   s_w_user,
  input  logic                    s_w_last,
  input  logic                    s_w_valid,
  output logic                    s_w_ready,
  output logic [DATA_WIDTH-1:0]   m_w_data,
  output logic [DATA_WIDTH/8-1:0] m_w_strb,
  output logic [USER_WIDTH-1:0]   m_w_user,
  output logic                    m_w_last,
  output logic                    m_w_valid,
  input  logic                    m_w_ready,
  // B
  output logic [1:0]              s_b_resp,
  output logic [ID_WIDTH-1:0]     s_b_id,
  output logic [USER_WIDTH-1:0]   s_b_user,
  output logic                    s_b_valid,
  input  logic                    s_b_ready,
  input  logic [1:0]              m_b_resp,
  input  logic [ID_WIDTH-1:0]     m_b_id,
  input  logic [USER_WIDTH-1:0]   m_b_user,
  input  logic                    m_b_valid,
  output logic                    m_b_ready,
  // AR
  input  logic [ADDR_WIDTH-1:0]   s_ar_addr,
  input  logic [2:0]              s_ar_prot,
  input  logic [3:0]              s_ar_region,
  input  logic [7:0]              s_ar_len,
  input  logic [2:0]              s_ar_size,
  input  logic [1:0]              s_ar_burst,
  input  logic                    s_ar_lock,
  input  logic [3:0]              s_ar_cache,
  input  logic [3:0]              s_ar_qos,
  input  logic [ID_WIDTH-1:0]     s_ar_id,
  input  logic [USER_WIDTH-1:0]   s_ar_user,
  input  logic                    s_ar_valid,
  output logic                    s_ar_ready,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr,
  output logic [2:0]              m_ar_prot,
  output logic [3:0]              m_ar_region,
  output logic [7:0]              m_ar_len,
  output logic [2:0]              m_ar_size,
  output logic [1:0]              m_ar_burst,
  output logic                    m_ar_lock,
  output logic [3:0]              m_ar_cache,
  output logic [3:0]              m_ar_qos,
  output logic [ID_WIDTH-1:0]     m_ar_id,
  output logic [USER_WIDTH-1:0]   m_ar_user,
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  // R
  output logic [DATA_WIDTH-1:0]   s_r_data,
  output logic [1:0]              s_r_resp,
  output logic                    s_r_last,
  output logic [ID_WIDTH-1:0]     s_r_id,
  output logic [USER_WIDTH-1:0]   s_r_user,
  output logic                    s_r_valid,
  input  logic                    s_r_ready,
  input  logic [DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]              m_r_resp,
  input  logic                    m_r_last,
  input  logic [ID_WIDTH-1:0]     m_r_id,
  input  logic [USER_WIDTH-1:0]   m_r_user,
  input  logic                    m_r_valid,
  output logic                    m_r_ready,
  // control / status
  input  logic                    drain_req,
  output logic                    drain_ack,
  output logic [WR_CW-1:0]        wr_outstanding,
  output logic [RD_CW-1:0]        rd_outstanding,
  output logic                    protocol_err
);

  localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_WR_OUTST);
  localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_RD_OUTST);

  state_e           state_q, state_d;
  logic             run, idle;
  logic [WR_CW-1:0] wr_cnt, w_pend;
  logic [RD_CW-1:0] rd_cnt;
  logic             wr_uf, rd_uf, wp_uf;
  logic             err_q;
  logic             allow_aw, allow_ar, allow_w;
  logic             aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

  // Payload pass-through
  assign m_aw_addr   = s_aw_addr;
  assign m_aw_prot   = s_aw_prot;
  assign m_aw_region = s_aw_region;
  assign m_aw_len    = s_aw_len;
  assign m_aw_size   = s_aw_size;
  assign m_aw_burst  = s_aw_burst;
  assign m_aw_lock   = s_aw_lock;
  assign m_aw_cache  = s_aw_cache;
  assign m_aw_qos    = s_aw_qos;
  assign m_aw_id     = s_aw_id;
  assign m_aw_user   = s_aw_user;

  assign m_w_data    = s_w_data;
  assign m_w_strb    = s_w_strb;
  assign m_w_user    = s_w_user;
  assign m_w_last    = s_w_last;

  assign s_b_resp    = m_b_resp;
  assign s_b_id      = m_b_id;
  assign s_b_user    = m_b_user;

  assign m_ar_addr   = s_ar_addr;
  assign m_ar_prot   = s_ar_prot;
  assign m_ar_region = s_ar_region;
  assign m_ar_len    = s_ar_len;
  assign m_ar_size   = s_ar_size;
  assign m_ar_burst  = s_ar_burst;
  assign m_ar_lock   = s_ar_lock;
  assign m_ar_cache  = s_ar_cache;
  assign m_ar_qos    = s_ar_qos;
  assign m_ar_id     = s_ar_id;
  assign m_ar_user   = s_ar_user;

  assign s_r_data    = m_r_data;
  assign s_r_resp    = m_r_resp;
  assign s_r_last    = m_r_last;
  assign s_r_id      = m_r_id;
  assign s_r_user    = m_r_user;

  // Allow terms use registered state only, so valid/ready never form a loop.
  assign allow_aw = ~rst & run & (wr_cnt < WR_MAX);
  assign allow_ar = ~rst & run & (rd_cnt < RD_MAX);
  assign allow_w  = ~rst & (w_pend != '0);

  assign m_aw_valid = s_aw_valid & allow_aw;
  assign s_aw_ready = m_aw_ready & allow_aw;
  assign m_ar_valid = s_ar_valid & allow_ar;
  assign s_ar_ready = m_ar_ready & allow_ar;
  assign m_w_valid  = s_w_valid  & allow_w;
  assign s_w_ready  = m_w_ready  & allow_w;
  assign s_b_valid  = m_b_valid;
  assign m_b_ready  = s_b_ready;
  assign s_r_valid  = m_r_valid;
  assign m_r_ready  = s_r_ready;

  assign aw_hs     = s_aw_valid & m_aw_ready & allow_aw;
  assign w_last_hs = s_w_valid & m_w_ready & allow_w & s_w_last;
  assign b_hs      = m_b_valid & s_b_ready;
  assign ar_hs     = s_ar_valid & m_ar_ready & allow_ar;
  assign r_last_hs = m_r_valid & s_r_ready & m_r_last;

  axi_ddr_txn_counter #(.MAX(MAX_WR_OUTST)) u_wr_cnt (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (aw_hs),
    .dec_i       (b_hs),
    .count_o     (wr_cnt),
    .underflow_o (wr_uf)
  );

  axi_ddr_txn_counter #(.MAX(MAX_RD_OUTST)) u_rd_cnt (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (ar_hs),
    .dec_i       (r_last_hs),
    .count_o     (rd_cnt),
    .underflow_o (rd_uf)
  );

  axi_ddr_txn_counter #(.MAX(MAX_WR_OUTST)) u_w_pend (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (aw_hs),
    .dec_i       (w_last_hs),
    .count_o     (w_pend),
    .underflow_o (wp_uf)
  );

  // w_pend cannot underflow since W is gated on it; folding it in is harmless.
  always_ff @(posedge clk) begin
    if (rst)                         err_q <= 1'b0;
    else if (wr_uf | rd_uf | wp_uf)  err_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN: begin
        if (!drain_req)                                        state_d = RUN;
        else if (wr_cnt == '0 && rd_cnt == '0 && w_pend == '0) state_d = IDLE;
      end
      IDLE:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    run  = 1'b0;
    idle = 1'b0;
    case (state_q)
      RUN:     run  = 1'b1;
      IDLE:    idle = 1'b1;
      default: ;
    endcase
  end

  assign drain_ack      = idle & ~rst;
  assign protocol_err   = err_q & ~rst;
  assign wr_outstanding = rst ? '0 : wr_cnt;
  assign rd_outstanding = rst ? '0 : rd_cnt;

endmodule

// File: tb/tb_axi_ddr_txn_limiter.sv
// Directed bench for axi_ddr_txn_limiter: cycle table for the write path plus
// hand sequences for W gating, drain, and reset mid-burst.
module tb_axi_ddr_txn_limiter;
  import axi_ddr_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned IW  = 4;
  localparam int unsigned UW  = 1;
  localparam int unsigned MWR = 2;
  localparam int unsigned MRD = 4;
  localparam int unsigned WCW = $clog2(MWR + 1);
  localparam int unsigned RCW = $clog2(MRD + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] s_aw_addr, m_aw_addr, s_ar_addr, m_ar_addr;
  logic [2:0] s_aw_prot, m_aw_prot, s_ar_prot, m_ar_prot;
  logic [3:0] s_aw_region, m_aw_region, s_ar_region, m_ar_region;
  logic [7:0] s_aw_len, m_aw_len, s_ar_len, m_ar_len;
  logic [2:0] s_aw_size, m_aw_size, s_ar_size, m_ar_size;
  logic [1:0] s_aw_burst, m_aw_burst, s_ar_burst, m_ar_burst;
  logic s_aw_lock, m_aw_lock, s_ar_lock, m_ar_lock;
  logic [3:0] s_aw_cache, m_aw_cache, s_ar_cache, m_ar_cache;
  logic [3:0] s_aw_qos, m_aw_qos, s_ar_qos, m_ar_qos;
  logic [IW-1:0] s_aw_id, m_aw_id, s_ar_id, m_ar_id;
  logic [UW-1:0] s_aw_user, m_aw_user, s_ar_user, m_ar_user;
  logic s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
  logic s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
  logic [DW-1:0] s_w_data, m_w_data;
  logic [DW/8-1:0] s_w_strb, m_w_strb;
  logic [UW-1:0] s_w_user, m_w_user;
  logic s_w_last, m_w_last, s_w_valid, s_w_ready, m_w_valid, m_w_ready;
  logic [1:0] s_b_resp, m_b_resp;
  logic [IW-1:0] s_b_id, m_b_id;
  logic [UW-1:0] s_b_user, m_b_user;
  logic s_b_valid, s_b_ready, m_b_valid, m_b_ready;
  logic [DW-1:0] s_r_data, m_r_data;
  logic [1:0] s_r_resp, m_r_resp;
  logic s_r_last, m_r_last;
  logic [IW-1:0] s_r_id, m_r_id;
  logic [UW-1:0] s_r_user, m_r_user;
  logic s_r_valid, s_r_ready, m_r_valid, m_r_ready;
  logic drain_req, drain_ack, protocol_err;
  logic [WCW-1:0] wr_outstanding;
  logic [RCW-1:0] rd_outstanding;

  axi_ddr_txn_limiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW),
    .MAX_WR_OUTST(MWR), .MAX_RD_OUTST(MRD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_aw_addr(s_aw_addr), .s_aw_prot(s_aw_prot), .s_aw_region(s_aw_region),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_aw_lock(s_aw_lock), .s_aw_cache(s_aw_cache), .s_aw_qos(s_aw_qos),
    .s_aw_id(s_aw_id), .s_aw_user(s_aw_user), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot), .m_aw_region(m_aw_region),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
    .m_aw_lock(m_aw_lock), .m_aw_cache(m_aw_cache), .m_aw_qos(m_aw_qos),
    .m_aw_id(m_aw_id), .m_aw_user(m_aw_user), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_user(s_w_user), .s_w_last(s_w_last),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_user(m_w_user), .m_w_last(m_w_last),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .s_b_resp(s_b_resp), .s_b_id(s_b_id), .s_b_user(s_b_user), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .m_b_resp(m_b_resp), .m_b_id(m_b_id), .m_b_user(m_b_user), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_prot(s_ar_prot), .s_ar_region(s_ar_region),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_ar_lock(s_ar_lock), .s_ar_cache(s_ar_cache), .s_ar_qos(s_ar_qos),
    .s_ar_id(s_ar_id), .s_ar_user(s_ar_user), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot), .m_ar_region(m_ar_region),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_ar_lock(m_ar_lock), .m_ar_cache(m_ar_cache), .m_ar_qos(m_ar_qos),
    .m_ar_id(m_ar_id), .m_ar_user(m_ar_user), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_id(s_r_id),
    .s_r_user(s_r_user), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_id(m_r_id),
    .m_r_user(m_r_user), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .drain_req(drain_req), .drain_ack(drain_ack),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .protocol_err(protocol_err)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-cycle write-path vectors: inputs held for one cycle, outputs sampled before the edge.
  typedef struct packed {
    logic aw_v, aw_r, w_v, w_l, w_r, b_v, b_r;
  } vin_t;
  typedef struct packed {
    logic maw_v, saw_r, mw_v, sw_r, sb_v, mb_r;
    logic [1:0] wr;
    logic perr;
  } vout_t;
  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  vec_t tbl[$];

  task automatic idle();
    s_aw_valid = 0; m_aw_ready = 0; s_w_valid = 0; s_w_last = 0; m_w_ready = 0;
    m_b_valid = 0; s_b_ready = 0; s_ar_valid = 0; m_ar_ready = 0;
    m_r_valid = 0; s_r_ready = 0; m_r_last = 0; drain_req = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    s_aw_valid = 1; m_aw_ready = 1; s_ar_valid = 1; m_ar_ready = 1;
    s_w_valid = 1; m_w_ready = 1; drain_req = 0;
    #1 chk("rst_gated", {m_aw_valid, m_ar_valid, m_w_valid, s_aw_ready, s_ar_ready, s_w_ready}, 6'b0);
    @(negedge clk);
    rst = 0;
    idle();
    #1 chk("rst_state", {drain_ack, protocol_err, wr_outstanding, rd_outstanding}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    s_aw_addr = 32'h8000_1000; s_aw_prot = 3'd2; s_aw_region = 4'd1; s_aw_len = 8'd0;
    s_aw_size = 3'd2; s_aw_burst = BURST_INCR; s_aw_lock = 0; s_aw_cache = 4'h3;
    s_aw_qos = 4'h5; s_aw_id = 4'hA; s_aw_user = 1'b1;
    s_ar_addr = 32'h4000_2000; s_ar_prot = 3'd0; s_ar_region = 4'd0; s_ar_len = 8'd0;
    s_ar_size = 3'd2; s_ar_burst = BURST_INCR; s_ar_lock = 0; s_ar_cache = 4'h0;
    s_ar_qos = 4'h0; s_ar_id = 4'h3; s_ar_user = 1'b0;
    s_w_data = '0; s_w_strb = 4'hF; s_w_user = 1'b0;
    m_b_resp = RESP_OKAY; m_b_id = 4'hA; m_b_user = 1'b0;
    m_r_data = '0; m_r_resp = RESP_OKAY; m_r_id = 4'h3; m_r_user = 1'b0;
    idle();

    //             aw_v aw_r w_v w_l w_r b_v b_r      maw saw mw sw sb mb wr perr
    tbl.push_back({7'b1_0_0_0_1_0_0, 9'b1_0_0_0_0_0_00_0}); // AW stalled downstream
    tbl.push_back({7'b1_1_1_0_1_0_0, 9'b1_1_0_0_0_0_00_0}); // AW#1; W held same cycle
    tbl.push_back({7'b1_1_1_0_1_0_0, 9'b1_1_1_1_0_0_01_0}); // AW#2; W now flows
    tbl.push_back({7'b1_1_1_1_1_0_0, 9'b0_0_1_1_0_0_10_0}); // at limit: AW#3 blocked
    tbl.push_back({7'b1_1_0_0_1_1_1, 9'b0_0_0_1_1_1_10_0}); // B returns
    tbl.push_back({7'b1_1_0_0_1_1_1, 9'b1_1_0_1_1_1_01_0}); // AW#3 + B together
    tbl.push_back({7'b0_1_1_1_1_0_0, 9'b0_1_1_1_0_0_01_0});
    tbl.push_back({7'b0_1_1_1_1_0_0, 9'b0_1_1_1_0_0_01_0});
    tbl.push_back({7'b0_1_1_0_1_0_0, 9'b0_1_0_0_0_0_01_0}); // no pending AW: W blocked
    tbl.push_back({7'b0_0_0_0_0_1_1, 9'b0_0_0_0_1_1_01_0});
    tbl.push_back({7'b0_0_0_0_0_1_1, 9'b0_0_0_0_1_1_00_0}); // spurious B at zero
    tbl.push_back({7'b0_0_0_0_0_1_0, 9'b0_0_0_0_1_0_00_1});
    tbl.push_back({7'b0_0_0_0_0_0_0, 9'b0_0_0_0_0_0_00_1});

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      vout_t act;
      @(negedge clk);
      s_aw_valid = tbl[i].i.aw_v; m_aw_ready = tbl[i].i.aw_r;
      s_w_valid  = tbl[i].i.w_v;  s_w_last   = tbl[i].i.w_l; m_w_ready = tbl[i].i.w_r;
      m_b_valid  = tbl[i].i.b_v;  s_b_ready  = tbl[i].i.b_r;
      #1;
      act = {m_aw_valid, s_aw_ready, m_w_valid, s_w_ready, s_b_valid, m_b_ready,
             wr_outstanding, protocol_err};
      chk($sformatf("row%0d", i), act, tbl[i].o);
      if (i == 0) chk("aw_addr_pass", m_aw_addr, 32'h8000_1000);
    end

    // W gating: W waits for its AW, then a len=3 burst flows
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      s_w_valid = 1; s_w_last = 0; m_w_ready = 1; s_w_data = 32'hA0;
      #1 chk("wgate_pre", {m_w_valid, s_w_ready}, 2'b00);
    end
    @(negedge clk);
    s_aw_valid = 1; m_aw_ready = 1; s_aw_len = 8'd3;
    #1 chk("wgate_aw_cycle", {m_aw_valid, s_aw_ready, m_w_valid, s_w_ready}, 4'b1100);
    for (int b = 0; b < 4; b++) begin
      logic [DW-1:0] exp_d;
      exp_d = 32'hD000_0000 + DW'(b);
      @(negedge clk);
      s_aw_valid = 0; s_w_data = exp_d; s_w_last = (b == 3);
      #1 chk($sformatf("wgate_beat%0d", b), {m_w_valid, s_w_ready, m_w_last}, {2'b11, (b == 3)});
      chk("wgate_data", m_w_data, exp_d);
    end
    @(negedge clk);
    s_w_last = 0;
    #1 chk("wgate_post", {m_w_valid, s_w_ready, wr_outstanding}, {2'b00, 2'd1});

    // Drain with two reads outstanding
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      s_ar_valid = 1; m_ar_ready = 1;
      #1 chk("ar_accept", {s_ar_ready, m_ar_valid}, 2'b11);
    end
    @(negedge clk);
    s_ar_valid = 0; drain_req = 1;
    #1 chk("drain_start", {drain_ack, rd_outstanding}, {1'b0, 3'd2});
    @(negedge clk);
    s_ar_valid = 1;
    #1 chk("drain_ar_block", {s_ar_ready, m_ar_valid, drain_ack}, 3'b000);
    @(negedge clk);
    s_ar_valid = 0; m_r_valid = 1; s_r_ready = 1; m_r_last = 0; m_r_data = 32'h1234_5678;
    #1 chk("r_fwd", {s_r_valid, m_r_ready, s_r_data}, {2'b11, 32'h1234_5678});
    @(negedge clk);
    m_r_last = 1;
    #1 chk("r_nonlast", {rd_outstanding, drain_ack}, {3'd2, 1'b0});
    @(negedge clk);
    #1 chk("r_last1", {rd_outstanding, drain_ack}, {3'd1, 1'b0});
    @(negedge clk);
    m_r_valid = 0; m_r_last = 0;
    #1 chk("drain_zero", {rd_outstanding, drain_ack}, {3'd0, 1'b0});
    @(negedge clk);
    #1 chk("drain_ack_rise", drain_ack, 1'b1);
    @(negedge clk);
    s_ar_valid = 1; drain_req = 0;
    #1 chk("idle_ar_block", {drain_ack, s_ar_ready, m_ar_valid}, 3'b100);
    @(negedge clk);
    #1 chk("resume", {drain_ack, s_ar_ready, m_ar_valid}, 3'b011);

    // Reset in the middle of a W burst with three reads outstanding
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      s_ar_valid = 1; m_ar_ready = 1;
    end
    @(negedge clk);
    s_ar_valid = 0; s_aw_valid = 1; m_aw_ready = 1; s_aw_len = 8'd3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      s_aw_valid = 0; s_w_valid = 1; m_w_ready = 1; s_w_last = 0;
    end
    @(negedge clk);
    #1 chk("pre_rst_cnt", {wr_outstanding, rd_outstanding}, {2'd1, 3'd3});
    do_reset();
    @(negedge clk);
    s_aw_valid = 1; m_aw_ready = 1; s_w_valid = 1; m_w_ready = 1;
    #1 chk("post_rst_aw", {s_aw_ready, m_aw_valid, m_w_valid, s_w_ready}, 4'b1100);
    @(negedge clk);
    idle();
    #1 chk("post_rst_cnt", {wr_outstanding, rd_outstanding}, {2'd1, 3'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_ddr_txn_limiter.md
# axi_ddr_txn_limiter

Parametrised AXI4 pass-through between the SoC's external DDR master port and the DDR controller. It caps outstanding write and read transactions independently and holds W beats until their AW has been accepted downstream. It also provides a drain handshake so that the DDR side can be reset or reclocked only once the bus is quiescent. Successor to the fixed 32-bit/4-bit-ID DDR port, now generic in address, data, ID and user widths.

## Interface
- ADDR_WIDTH, 32, AW/AR address width
- DATA_WIDTH, 32, W/R data width; wstrb is DATA_WIDTH/8
- ID_WIDTH, 4, transaction ID width
- USER_WIDTH, 1, user sideband width on all channels
- MAX_WR_OUTST, 8, maximum accepted-but-unresponded writes (≥1)
- MAX_RD_OUTST, 8, maximum accepted-but-uncompleted reads (≥1)
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- s_aw_* / m_aw_*  in/out  bundle  slave-side and master-side AW: addr, prot, region, len, size, burst, lock, cache, qos, id, user, valid, ready
- s_w_* / m_w_*  in/out  bundle  W: data, strb, user, last, valid, ready
- s_b_* / m_b_*  out/in  bundle  B: resp, id, user, valid, ready
- s_ar_* / m_ar_*  in/out  bundle  AR: same fields as AW
- s_r_* / m_r_*  out/in  bundle  R: data, resp, last, id, user, valid, ready
- drain_req  in  1  request to quiesce the DDR port
- drain_ack  out  1  high while quiescent (state IDLE)
- wr_outstanding  out  $clog2(MAX_WR_OUTST+1)  current write count
- rd_outstanding  out  $clog2(MAX_RD_OUTST+1)  current read count
- protocol_err  out  1  sticky; B or R-last received with no matching outstanding transaction

## Operation
- Payload fields pass through unmodified. Only valid/ready are gated: m_x_valid = s_x_valid & allow_x and s_x_ready = m_x_ready & allow_x. B and R are never gated.
- allow_aw = (state==RUN) & (wr_cnt < MAX_WR_OUTST). allow_ar = (state==RUN) & (rd_cnt < MAX_RD_OUTST).
- allow_w = (w_pend != 0), where w_pend counts AW handshakes minus W handshakes with wlast.
- wr_cnt: +1 on m_aw handshake, −1 on m_b handshake. Both in the same cycle leaves it unchanged.
- rd_cnt: +1 on m_ar handshake, −1 on m_r handshake with rlast. Both in the same cycle leaves it unchanged.
- Decrement at zero: the counter stays 0, protocol_err is set, and the response is still forwarded upstream.
- protocol_err is cleared only by rst.
- FSM states: RUN, DRAIN, IDLE.
  - RUN → DRAIN when drain_req=1.
  - DRAIN → IDLE when wr_cnt, rd_cnt and w_pend are all 0.
  - DRAIN → RUN when drain_req=0 before quiescence.
  - IDLE → RUN when drain_req=0.
- In DRAIN and IDLE, new AW/AR are blocked. Pending W beats, B and R continue to flow.
- Reset mid-operation: all counters go to 0 and state goes to RUN. The downstream controller must be reset in the same cycle; in-flight transactions are discarded.

## Timing
- Zero-cycle latency on all channels; the block is combinational pass-through.
- Every allow_x term depends only on registers, never on same-cycle valid/ready, so the block adds no combinational loop.
- A W beat presented in the same cycle as its AW handshake is held. It is forwarded from the next cycle.
- After an increment to the limit at edge k, the corresponding s_x_ready is 0 from cycle k+1.
- A decrement at edge k reopens acceptance in cycle k+1.
- drain_ack rises one cycle after the edge at which the counters first read all-zero in DRAIN. It falls in the cycle after drain_req is sampled low.
- Values during and immediately after rst:
  - drain_ack=0, protocol_err=0, wr_outstanding=0, rd_outstanding=0.
  - All allow terms are 0 while rst is high, so m_aw_valid, m_ar_valid, m_w_valid, s_aw_ready, s_ar_ready and s_w_ready are all 0.

## Structure
- The shared package axi_ddr_pkg holds:
  - the state enum (RUN/DRAIN/IDLE)
  - AXI resp and burst constants
  - a count-width helper function
- One sub-module, axi_ddr_txn_counter: a parametrised up/down counter with a MAX parameter, simultaneous inc/dec handling, floor at zero, and an underflow pulse output.
- It is instantiated three times: wr_cnt, rd_cnt, w_pend.
- w_pend's MAX is MAX_WR_OUTST.

## Test plan
- **Write limit.** MAX_WR_OUTST=2, m_aw_ready=1, three back-to-back AWs, B withheld.
  - Two pass; third sees s_aw_ready=0 and wr_outstanding=2.
  - One B handshake → third accepted the next cycle.
- **W gating.** W valid asserted 3 cycles before AW.
  - m_w_valid=0 until the cycle after the AW handshake.
  - A len=3 burst then forwards 4 beats, and w_pend returns to 0 after wlast.
- **Simultaneous events.** wr_outstanding=1, AW handshake and B handshake in the same cycle → wr_outstanding stays 1, protocol_err=0.
- **Drain.** Two reads outstanding, drain_req=1.
  - AR blocked immediately; drain_ack=0 until the last rlast handshake, then 1 one cycle later.
  - drain_req=0 → drain_ack=0 and AR accepted again the next cycle.
- **Spurious response.** wr_outstanding=0, m_b_valid=1 → s_b_valid=1 forwarded, wr_outstanding=0, protocol_err=1 and stays 1 until rst.
- **Reset mid-burst.** rst during a 4-beat W burst with 3 reads outstanding.
  - All gated valid/ready signals are 0; counters 0, state RUN, drain_ack=0.
  - A new AW is accepted the cycle after rst falls.
